pipe_stage_reg: RTL and testbench

Parametrised, elastic pipeline stage register that replaces the fixed-field latch bundle between datapath stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary-width packed payload with a valid/ready handshake. A two-entry skid buffer breaks the combinational ready path. The stage also provides a global hold (cache-miss stall, driven by !ihit or !dhit), a synchronous flush for branch/jump squash, and saturating stall and bubble counters for performance analysis.

---
 rtl/pipe_stage_reg_if.sv | 30 +++
 rtl/pipe_stage_reg.sv | 112 +++++++++++
 tb/tb_pipe_stage_reg.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - valid/ready handshake bundle for an elastic pipeline stage
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    // slave: the stage itself; master: the surrounding upstream/downstream logic
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic pipeline stage register with skid buffer, hold, flush and perf counters
module pipe_stage_reg #(
    parameter int                 DATA_W     = 32,
    parameter logic [DATA_W-1:0]  FLUSH_DATA = '0,
    parameter int                 CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    pipe_stage_reg_if.slave  bus,
    input  logic             hold,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  main_q, main_d;
    logic [DATA_W-1:0]  skid_q, skid_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [CNT_W-1:0]   bubble_q, bubble_d;

    logic acc;
    logic pop;
    logic stall_inc;
    logic bubble_inc;

    // Ready is a function of registered state and hold only, so out_ready never reaches in_ready.
    assign bus.in_ready  = (state_q != FULL) && !hold;
    assign bus.out_valid = (state_q != EMPTY) && !hold;
    assign bus.out_data  = main_q;
    assign occupancy     = state_q;
    assign stall_cnt     = stall_q;
    assign bubble_cnt    = bubble_q;

    assign acc = bus.in_valid && bus.in_ready;
    assign pop = bus.out_valid && bus.out_ready;

    assign stall_inc  = (state_q != EMPTY) && (hold || !bus.out_ready) && !flush;
    assign bubble_inc = (state_q == EMPTY) && !hold && !flush;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = FLUSH_DATA;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_d  = bus.in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        main_d = bus.in_data;
                    end else if (acc) begin
                        skid_d  = bus.in_data;
                        state_d = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (stall_inc && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
        if (bubble_inc && (bubble_q != {CNT_W{1'b1}})) begin
            bubble_d = bubble_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - table-driven bench for pipe_stage_reg
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST, hold, flush;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt, bubble_cnt;

    logic        rst2, hold2, flush2;
    logic [1:0]  occ2;
    logic [3:0]  stall2, bubble2;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg_if #(.DATA_W(32)) bus  ();
    pipe_stage_reg_if #(.DATA_W(8))  bus2 ();

    pipe_stage_reg #(.DATA_W(32), .FLUSH_DATA(NOP), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .bus(bus), .hold(hold), .flush(flush),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.DATA_W(8), .FLUSH_DATA(8'h00), .CNT_W(4)) dut2 (
        .CLK(CLK), .RST(rst2), .bus(bus2), .hold(hold2), .flush(flush2),
        .occupancy(occ2), .stall_cnt(stall2), .bubble_cnt(bubble2)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] din;
        logic        ordy;
        logic        hld;
        logic        fl;
        logic        ov;
        logic [31:0] dout;
        logic        ir;
        logic [1:0]  occ;
        logic [15:0] stall;
        logic [15:0] bub;
    } vec_t;

    vec_t vt [22];

    task automatic drive(input logic iv, input logic [31:0] d, input logic ordy,
                         input logic h, input logic f);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        hold          = h;
        flush         = f;
    endtask

    initial begin
        // iv  din     ordy hld fl | ov  dout    ir  occ stall bub
        vt[0]  = '{1'b1, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 2'd0, 16'd0, 16'd0};
        vt[1]  = '{1'b1, 32'h2, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1, 1'b1, 2'd1, 16'd0, 16'd1};
        vt[2]  = '{1'b1, 32'h3, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2, 1'b1, 2'd1, 16'd0, 16'd1};
        vt[3]  = '{1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 1'b1, 32'h3, 1'b1, 2'd1, 16'd0, 16'd1};
        vt[4]  = '{1'b1, 32'h5, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4, 1'b1, 2'd1, 16'd0, 16'd1};
        vt[5]  = '{1'b1, 32'h6, 1'b1, 1'b0, 1'b0, 1'b1, 32'h5, 1'b1, 2'd1, 16'd0, 16'd1};
        vt[6]  = '{1'b1, 32'h7, 1'b1, 1'b0, 1'b0, 1'b1, 32'h6, 1'b1, 2'd1, 16'd0, 16'd1};
        vt[7]  = '{1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 1'b1, 32'h7, 1'b1, 2'd1, 16'd0, 16'd1};
        vt[8]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 1'b1, 2'd1, 16'd0, 16'd1};
        vt[9]  = '{1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 1'b1, 2'd0, 16'd0, 16'd1};
        vt[10] = '{1'b1, 32'hB, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA, 1'b1, 2'd1, 16'd0, 16'd2};
        vt[11] = '{1'b1, 32'hE, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA, 1'b0, 2'd2, 16'd1, 16'd2};
        vt[12] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA, 1'b0, 2'd2, 16'd2, 16'd2};
        vt[13] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hB, 1'b1, 2'd1, 16'd2, 16'd2};
        vt[14] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hB, 1'b1, 2'd0, 16'd2, 16'd2};
        vt[15] = '{1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 1'b0, 32'hB, 1'b1, 2'd0, 16'd2, 16'd3};
        vt[16] = '{1'b1, 32'hB, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA, 1'b1, 2'd1, 16'd2, 16'd4};
        vt[17] = '{1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA, 1'b0, 2'd2, 16'd3, 16'd4};
        vt[18] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, NOP,   1'b1, 2'd0, 16'd3, 16'd4};
        vt[19] = '{1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 1'b0, NOP,   1'b1, 2'd0, 16'd3, 16'd5};
        vt[20] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, NOP,   1'b1, 2'd0, 16'd3, 16'd5};
        vt[21] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, NOP,   1'b0, 2'd0, 16'd3, 16'd6};

        RST = 1'b1; rst2 = 1'b1; hold2 = 1'b0; flush2 = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        bus2.in_valid = 1'b0; bus2.in_data = 8'h0; bus2.out_ready = 1'b0;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_occupancy", {30'b0, occupancy}, 32'd0);
        chk("rst_stall", {16'b0, stall_cnt}, 32'd0);
        chk("rst_bubble", {16'b0, bubble_cnt}, 32'd0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        hold = 1'b1;
        #1;
        chk("rst_in_ready_hold", {31'b0, bus.in_ready}, 32'd0);
        hold = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;

        for (int i = 0; i < 22; i++) begin
            drive(vt[i].iv, vt[i].din, vt[i].ordy, vt[i].hld, vt[i].fl);
            @(negedge CLK);
            chk($sformatf("v%0d_out_valid", i), {31'b0, bus.out_valid}, {31'b0, vt[i].ov});
            chk($sformatf("v%0d_out_data", i), bus.out_data, vt[i].dout);
            chk($sformatf("v%0d_in_ready", i), {31'b0, bus.in_ready}, {31'b0, vt[i].ir});
            chk($sformatf("v%0d_occupancy", i), {30'b0, occupancy}, {30'b0, vt[i].occ});
            chk($sformatf("v%0d_stall", i), {16'b0, stall_cnt}, {16'b0, vt[i].stall});
            chk($sformatf("v%0d_bubble", i), {16'b0, bubble_cnt}, {16'b0, vt[i].bub});
            @(posedge CLK); #1;
        end

        // Hold in FULL: frozen for three cycles, then A and B drain in order.
        drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        @(posedge CLK); #1;
        drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        @(posedge CLK); #1;
        drive(1'b1, 32'hF, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        chk("hold_pre_occ", {30'b0, occupancy}, 32'd2);
        chk("hold_pre_stall", {16'b0, stall_cnt}, 32'd4);
        chk("hold_pre_bubble", {16'b0, bubble_cnt}, 32'd7);
        for (int k = 0; k < 3; k++) begin
            if (k != 0) @(negedge CLK);
            chk($sformatf("hold%0d_out_valid", k), {31'b0, bus.out_valid}, 32'd0);
            chk($sformatf("hold%0d_in_ready", k), {31'b0, bus.in_ready}, 32'd0);
            @(posedge CLK); #1;
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        chk("hold_stall_after", {16'b0, stall_cnt}, 32'd7);
        chk("hold_rel_valid0", {31'b0, bus.out_valid}, 32'd1);
        chk("hold_rel_data0", bus.out_data, 32'hA);
        @(posedge CLK);
        @(negedge CLK);
        chk("hold_rel_valid1", {31'b0, bus.out_valid}, 32'd1);
        chk("hold_rel_data1", bus.out_data, 32'hB);
        @(posedge CLK);
        @(negedge CLK);
        chk("hold_drained_occ", {30'b0, occupancy}, 32'd0);
        chk("hold_drained_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("hold_stall_final", {16'b0, stall_cnt}, 32'd7);

        // Bubble counter saturation on the 4-bit instance, then reset mid-FULL under hold.
        rst2 = 1'b0;
        repeat (14) @(posedge CLK);
        @(negedge CLK);
        chk("sat_bubble_14", {28'b0, bubble2}, 32'd14);
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        chk("sat_bubble_20", {28'b0, bubble2}, 32'd15);
        bus2.in_valid = 1'b1; bus2.in_data = 8'hA; bus2.out_ready = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        bus2.in_data = 8'hB;
        @(posedge CLK);
        @(negedge CLK);
        chk("sat_full_occ", {30'b0, occ2}, 32'd2);
        chk("sat_full_stall", {28'b0, stall2}, 32'd1);
        chk("sat_full_data", {24'b0, bus2.out_data}, 32'hA);
        bus2.in_valid = 1'b0;
        rst2 = 1'b1; hold2 = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        rst2 = 1'b0; hold2 = 1'b0;
        #1;
        chk("rst2_occ", {30'b0, occ2}, 32'd0);
        chk("rst2_stall", {28'b0, stall2}, 32'd0);
        chk("rst2_bubble", {28'b0, bubble2}, 32'd0);
        chk("rst2_out_valid", {31'b0, bus2.out_valid}, 32'd0);
        chk("rst2_out_data", {24'b0, bus2.out_data}, 32'd0);
        chk("rst2_in_ready", {31'b0, bus2.in_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
